// File: rtl/rr_onehot_mux.sv
// ============================================================================
// rr_onehot_mux
// ----------------------------------------------------------------------------
// Registered N-channel multiplexer with a built-in round-robin arbiter and an
// optional packet-lock mode. The arbiter picks one requesting channel per
// cycle. The selected beat is captured in a single output register before it
// leaves the block.
//
// Parameters
//   SEL_WIDTH  number of input channels (>= 1)
//   WIDTH      data width per channel
//   PKT_MODE   1: hold the grant from a packet's first beat through its
//                 i_last beat; 0: arbitrate on every beat
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous, active-low reset
//   i         channel k data at [k*WIDTH +: WIDTH]
//   i_valid   per-channel beat valid
//   i_last    per-channel last-beat flag (qualified by i_valid)
//   i_ready   per-channel accept, combinational, at most one bit high
//   o         registered output data
//   o_valid   output register holds a beat
//   o_last    registered i_last of the accepted beat
//   o_sel     one-hot channel that sourced the current output beat
//   o_ready   downstream accept
//   o_locked  packet lock active (always 0 when PKT_MODE=0)
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. A producer that raises valid keeps data and last
// stable until it sees ready. Ready may depend combinationally on valid and on
// the downstream ready (o_ready -> i_ready, no skid buffer), never the
// reverse.
// ============================================================================
module rr_onehot_mux #(
    parameter int SEL_WIDTH = 2,
    parameter int WIDTH     = 1,
    parameter int PKT_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [SEL_WIDTH*WIDTH-1:0] i,
    input  logic [SEL_WIDTH-1:0]       i_valid,
    input  logic [SEL_WIDTH-1:0]       i_last,
    output logic [SEL_WIDTH-1:0]       i_ready,
    output logic [WIDTH-1:0]           o,
    output logic                       o_valid,
    output logic                       o_last,
    output logic [SEL_WIDTH-1:0]       o_sel,
    input  logic                       o_ready,
    output logic                       o_locked
);

    // Rotate a one-hot vector left by one position, wrapping the top bit to 0.
    // For SEL_WIDTH=1 this is the identity.
    function automatic logic [SEL_WIDTH-1:0] rotl1(input logic [SEL_WIDTH-1:0] v);
        logic [SEL_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            r[(k + 1) % SEL_WIDTH] = v[k];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     o_q,      o_d;
    logic                 valid_q,  valid_d;
    logic                 last_q,   last_d;
    logic [SEL_WIDTH-1:0] sel_q,    sel_d;
    logic [SEL_WIDTH-1:0] ptr_q,    ptr_d;
    logic                 lock_q,   lock_d;
    logic [SEL_WIDTH-1:0] owner_q,  owner_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                 ld;
    logic [SEL_WIDTH-1:0] rr_grant;
    logic                 rr_found;
    logic [SEL_WIDTH-1:0] grant;
    logic                 xfer;
    logic [WIDTH-1:0]     sel_data;
    logic                 sel_last;

    // The output register can take a new beat when it is empty or being drained.
    assign ld = ~valid_q | o_ready;

    // Circular first-valid search starting at the pointer position. The outer
    // loop picks the single start index marked by the one-hot pointer.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        for (int s = 0; s < SEL_WIDTH; s++) begin
            if (ptr_q[s]) begin
                for (int off = 0; off < SEL_WIDTH; off++) begin
                    if (!rr_found && i_valid[(s + off) % SEL_WIDTH]) begin
                        rr_grant[(s + off) % SEL_WIDTH] = 1'b1;
                        rr_found = 1'b1;
                    end
                end
            end
        end
    end

    // While locked, only the owner may be granted; if it is idle the cycle
    // becomes a bubble rather than letting another channel slip in.
    always_comb begin
        if (PKT_MODE != 0 && lock_q) begin
            grant = owner_q & i_valid;
        end else begin
            grant = rr_grant;
        end
    end

    assign i_ready = reset_n ? (grant & {SEL_WIDTH{ld}}) : '0;
    // grant only ever marks a valid channel, so any ready bit is a transfer.
    assign xfer    = |i_ready;

    // One-hot AND-OR data/last select.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            if (grant[k]) begin
                sel_data = sel_data | i[k*WIDTH +: WIDTH];
                sel_last = sel_last | i_last[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        o_d     = o_q;
        valid_d = valid_q;
        last_d  = last_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        owner_d = owner_q;

        if (ld) begin
            if (xfer) begin
                o_d     = sel_data;
                last_d  = sel_last;
                sel_d   = grant;
                valid_d = 1'b1;
            end else begin
                // Drained with nothing to replace it: data/last/sel keep
                // their last values, only the valid flag drops.
                valid_d = 1'b0;
            end
        end

        if (xfer) begin
            if (PKT_MODE == 0) begin
                ptr_d = rotl1(grant);
            end else if (sel_last) begin
                // Packet done: release the lock and move priority past it.
                ptr_d  = rotl1(grant);
                lock_d = 1'b0;
            end else begin
                // Mid-packet: pin the grant to this channel. The pointer stays
                // put so priority advances only once the packet ends.
                lock_d  = 1'b1;
                owner_d = grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= {{(SEL_WIDTH-1){1'b0}}, 1'b1};
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            o_q     <= o_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    assign o        = o_q;
    assign o_valid  = valid_q;
    assign o_last   = last_q;
    assign o_sel    = sel_q;
    assign o_locked = (PKT_MODE != 0) ? lock_q : 1'b0;

endmodule

// File: tb/tb_rr_onehot_mux.sv
// Bench for rr_onehot_mux: one per-beat instance (PKT_MODE=0) and one
// packet-lock instance (PKT_MODE=1), both SEL_WIDTH=4, WIDTH=8, sharing the
// same stimulus. Inputs change on the falling edge; i_ready is checked
// just after that, registered outputs 1 time unit after the rising edge.
module tb_rr_onehot_mux;

  localparam int N = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [N*W-1:0] i_bus;
  logic [N-1:0]   i_valid;
  logic [N-1:0]   i_last;
  logic           o_ready;

  logic [N-1:0]   rdy0,  rdy1;
  logic [W-1:0]   o0,    o1;
  logic           ov0,   ov1;
  logic           ol0,   ol1;
  logic [N-1:0]   sel0,  sel1;
  logic           lk0,   lk1;

  rr_onehot_mux #(.SEL_WIDTH(N), .WIDTH(W), .PKT_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i(i_bus), .i_valid(i_valid),
    .i_last(i_last), .i_ready(rdy0), .o(o0), .o_valid(ov0), .o_last(ol0),
    .o_sel(sel0), .o_ready(o_ready), .o_locked(lk0)
  );

  rr_onehot_mux #(.SEL_WIDTH(N), .WIDTH(W), .PKT_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i(i_bus), .i_valid(i_valid),
    .i_last(i_last), .i_ready(rdy1), .o(o1), .o_valid(ov1), .o_last(ol1),
    .o_sel(sel1), .o_ready(o_ready), .o_locked(lk1)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- vector table (PKT_MODE=0 instance) ----------------
  typedef struct {
    logic [N-1:0] vld;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] exp_o;
    logic         exp_v;
    logic [N-1:0] exp_sel;
  } vec_t;

  vec_t tbl[16];

  // ---------------- packet-mode step driver (dut1) ----------------
  task automatic pstep(input string nm, input logic rst_n, input logic [N-1:0] vld,
                       input logic [N-1:0] lst, input logic [W-1:0] d1,
                       input logic [N-1:0] e_rdy, input logic [W-1:0] e_o,
                       input logic e_v, input logic [N-1:0] e_sel,
                       input logic e_last, input logic e_lock);
    @(negedge clk);
    reset_n     = rst_n;
    i_valid     = vld;
    i_last      = lst;
    o_ready     = 1'b1;
    i_bus       = 32'hA3A2A1A0;
    i_bus[15:8] = d1;
    #1;
    chk({nm, ".i_ready"}, 32'(rdy1), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({nm, ".o"},        32'(o1),   32'(e_o));
    chk({nm, ".o_valid"},  32'(ov1),  32'(e_v));
    chk({nm, ".o_sel"},    32'(sel1), 32'(e_sel));
    chk({nm, ".o_last"},   32'(ol1),  32'(e_last));
    chk({nm, ".o_locked"}, 32'(lk1),  32'(e_lock));
  endtask

  initial begin
    // Hand-computed: channel k carries 8'hA0+k; pointer starts at channel 0.
    //            vld      ordy  rdy      o      v     sel
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 8'hA0, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 8'hA1, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 8'hA2, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 8'hA3, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 8'hA0, 1'b1, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 8'hA1, 1'b1, 4'b0010};
    // backpressure: three stalled cycles holding A1
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 8'hA1, 1'b1, 4'b0010};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 8'hA1, 1'b1, 4'b0010};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 8'hA1, 1'b1, 4'b0010};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 8'hA2, 1'b1, 4'b0100};
    // idle drain: valid drops, data/sel hold
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 8'hA2, 1'b0, 4'b0100};
    // search from channel 3 wraps to channel 0
    tbl[11] = '{4'b0001, 1'b1, 4'b0001, 8'hA0, 1'b1, 4'b0001};
    // pointer at 1: skips idle 1,2 and picks 3 ahead of 0
    tbl[12] = '{4'b1001, 1'b1, 4'b1000, 8'hA3, 1'b1, 4'b1000};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 8'hA3, 1'b0, 4'b1000};
    // empty register loads even with o_ready low, then stalls
    tbl[14] = '{4'b0010, 1'b0, 4'b0010, 8'hA1, 1'b1, 4'b0010};
    tbl[15] = '{4'b0010, 1'b0, 4'b0000, 8'hA1, 1'b1, 4'b0010};

    // ---------------- reset with everything requesting ----------------
    reset_n = 1'b0;
    i_valid = '1;
    i_last  = '0;
    o_ready = 1'b1;
    i_bus   = 32'hA3A2A1A0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d.i_ready0", c), 32'(rdy0), 32'h0);
      chk($sformatf("rst%0d.i_ready1", c), 32'(rdy1), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d.o", c),        32'(o0),   32'h0);
      chk($sformatf("rst%0d.o_valid", c),  32'(ov0),  32'h0);
      chk($sformatf("rst%0d.o_sel", c),    32'(sel0), 32'h0);
      chk($sformatf("rst%0d.o_locked", c), 32'(lk1),  32'h0);
    end

    // ---------------- table: round robin, backpressure, idle ----------------
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      reset_n = 1'b1;
      i_valid = tbl[v].vld;
      i_last  = '0;
      o_ready = tbl[v].ordy;
      i_bus   = 32'hA3A2A1A0;
      #1;
      chk($sformatf("vec%0d.i_ready", v), 32'(rdy0), 32'(tbl[v].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.o", v),       32'(o0),   32'(tbl[v].exp_o));
      chk($sformatf("vec%0d.o_valid", v), 32'(ov0),  32'(tbl[v].exp_v));
      chk($sformatf("vec%0d.o_sel", v),   32'(sel0), 32'(tbl[v].exp_sel));
      chk($sformatf("vec%0d.o_locked0", v), 32'(lk0), 32'h0);
    end

    // ---------------- packet lock, bubble, reset mid-packet ----------------
    //      name   rst   vld      last     ch1d   rdy      o      v     sel      lst   lock
    pstep("p_rst", 1'b0, 4'b0000, 4'b0000, 8'hA1, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0);
    // single-beat packet on ch0 moves pointer to ch1, no lock
    pstep("p_one", 1'b1, 4'b0001, 4'b0001, 8'hA1, 4'b0001, 8'hA0, 1'b1, 4'b0001, 1'b1, 1'b0);
    pstep("p_b1",  1'b1, 4'b0111, 4'b0000, 8'hB1, 4'b0010, 8'hB1, 1'b1, 4'b0010, 1'b0, 1'b1);
    pstep("p_b2",  1'b1, 4'b0111, 4'b0000, 8'hB2, 4'b0010, 8'hB2, 1'b1, 4'b0010, 1'b0, 1'b1);
    // owner idles: ch3 (and 0, 2) requesting but must not be granted
    pstep("p_bub1", 1'b1, 4'b1101, 4'b0000, 8'hB3, 4'b0000, 8'hB2, 1'b0, 4'b0010, 1'b0, 1'b1);
    pstep("p_bub2", 1'b1, 4'b1101, 4'b0000, 8'hB3, 4'b0000, 8'hB2, 1'b0, 4'b0010, 1'b0, 1'b1);
    pstep("p_b3",  1'b1, 4'b0111, 4'b0010, 8'hB3, 4'b0010, 8'hB3, 1'b1, 4'b0010, 1'b1, 1'b0);
    // next grant passes to ch2, which opens its own packet
    pstep("p_c2",  1'b1, 4'b0111, 4'b0000, 8'hB4, 4'b0100, 8'hA2, 1'b1, 4'b0100, 1'b0, 1'b1);
    pstep("p_mrst", 1'b0, 4'b0111, 4'b0000, 8'hB4, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0);
    pstep("p_post", 1'b1, 4'b1111, 4'b1111, 8'hA1, 4'b0001, 8'hA0, 1'b1, 4'b0001, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
